wave_channel_sched: RTL and testbench

//  Time-multiplexes one amplitude/phase compute datapath (amp * sin(phase) core) across NCH wave channels.

---
 rtl/wave_channel_sched.sv | 206 ++++++++++++++++++++
 tb/tb_wave_channel_sched.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_channel_sched.sv
// Shares one amp*sin(phase) datapath across NCH wave channels: one channel issued per cycle
// after each sample tick, results returned tagged with their channel number.
module wave_channel_sched #(
    parameter int NCH = 4,
    parameter int W   = 16,
    parameter int LAT = 2,
    localparam int CW = $clog2(NCH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cfg_we,
    output logic          cfg_ready,
    input  logic [CW-1:0] cfg_ch,
    input  logic [1:0]    cfg_sel,
    input  logic [W-1:0]  cfg_data,
    input  logic          run,
    input  logic          sample_tick,
    output logic          dp_valid,
    output logic [W-1:0]  dp_amp,
    output logic [W-1:0]  dp_phase,
    input  logic [W-1:0]  dp_result,
    output logic          out_valid,
    output logic [CW-1:0] out_ch,
    output logic [W-1:0]  out_data,
    output logic          frame_done,
    output logic          overrun,
    input  logic          overrun_clr,
    output logic [1:0]    dbg_state
);

    localparam logic [1:0]    S_IDLE  = 2'd0;
    localparam logic [1:0]    S_ISSUE = 2'd1;
    localparam logic [1:0]    S_DRAIN = 2'd2;
    localparam logic [CW-1:0] LAST_CH = CW'(NCH - 1);

    logic [1:0]    r_state;
    logic [CW-1:0] r_ch;

    logic [W-1:0]  r_amp [NCH];
    logic [W-1:0]  r_off [NCH];
    logic [W-1:0]  r_add [NCH];
    logic [W-1:0]  r_acc [NCH];

    logic          r_dp_valid;
    logic [W-1:0]  r_dp_amp;
    logic [W-1:0]  r_dp_phase;
    logic [CW-1:0] r_dp_ch;

    logic          r_tag_v  [LAT];
    logic [CW-1:0] r_tag_ch [LAT];

    logic          r_out_valid;
    logic [CW-1:0] r_out_ch;
    logic [W-1:0]  r_out_data;
    logic          r_frame_done;
    logic          r_overrun;

    logic          w_tick;
    logic          w_cfg_accept;
    logic          w_issue;
    logic [CW-1:0] w_issue_ch;
    logic          w_tags_busy;
    logic          w_pipe_busy;

    // Ticks with run=0 are invisible to the scheduler, including for overrun detection.
    assign w_tick       = sample_tick & run;
    assign w_cfg_accept = cfg_we & (r_state == S_IDLE);

    // Channel 0 is issued straight from IDLE on the tick edge so dp_valid rises the cycle after the tick.
    assign w_issue    = ((r_state == S_IDLE) & w_tick) | (r_state == S_ISSUE);
    assign w_issue_ch = (r_state == S_ISSUE) ? r_ch : '0;

    always_comb begin
        w_tags_busy = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            w_tags_busy = w_tags_busy | r_tag_v[i];
        end
    end

    assign w_pipe_busy = r_dp_valid | w_tags_busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_ch    <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_ISSUE: begin
                    if (w_issue) begin
                        if (w_issue_ch == LAST_CH) begin
                            r_state <= S_DRAIN;
                            r_ch    <= '0;
                        end else begin
                            r_state <= S_ISSUE;
                            r_ch    <= w_issue_ch + CW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (!w_pipe_busy) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ch    <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overrun <= 1'b0;
        end else if (w_tick && (r_state != S_IDLE)) begin
            r_overrun <= 1'b1;
        end else if (overrun_clr) begin
            r_overrun <= 1'b0;
        end
    end

    // A host clear of an accumulator wins over the issue-time advance on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                r_amp[i] <= '0;
                r_off[i] <= '0;
                r_add[i] <= '0;
                r_acc[i] <= '0;
            end
        end else begin
            if (w_issue) begin
                r_acc[w_issue_ch] <= r_acc[w_issue_ch] + r_add[w_issue_ch];
            end
            if (w_cfg_accept) begin
                case (cfg_sel)
                    2'd0:    r_amp[cfg_ch] <= cfg_data;
                    2'd1:    r_off[cfg_ch] <= cfg_data;
                    2'd2:    r_add[cfg_ch] <= cfg_data;
                    default: r_acc[cfg_ch] <= '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dp_valid <= 1'b0;
            r_dp_amp   <= '0;
            r_dp_phase <= '0;
            r_dp_ch    <= '0;
        end else if (w_issue) begin
            r_dp_valid <= 1'b1;
            r_dp_amp   <= r_amp[w_issue_ch];
            r_dp_phase <= r_acc[w_issue_ch] + r_off[w_issue_ch];
            r_dp_ch    <= w_issue_ch;
        end else begin
            r_dp_valid <= 1'b0;
        end
    end

    // Stage LAT-1 of the tag pipe lines up with the cycle dp_result is valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LAT; i++) begin
                r_tag_v[i]  <= 1'b0;
                r_tag_ch[i] <= '0;
            end
        end else begin
            r_tag_v[0]  <= r_dp_valid;
            r_tag_ch[0] <= r_dp_ch;
            for (int i = 1; i < LAT; i++) begin
                r_tag_v[i]  <= r_tag_v[i-1];
                r_tag_ch[i] <= r_tag_ch[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid  <= 1'b0;
            r_out_ch     <= '0;
            r_out_data   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_out_valid  <= r_tag_v[LAT-1];
            r_frame_done <= r_tag_v[LAT-1] && (r_tag_ch[LAT-1] == LAST_CH);
            if (r_tag_v[LAT-1]) begin
                r_out_ch   <= r_tag_ch[LAT-1];
                r_out_data <= dp_result;
            end
        end
    end

    assign cfg_ready  = (r_state == S_IDLE);
    assign dp_valid   = r_dp_valid;
    assign dp_amp     = r_dp_amp;
    assign dp_phase   = r_dp_phase;
    assign out_valid  = r_out_valid;
    assign out_ch     = r_out_ch;
    assign out_data   = r_out_data;
    assign frame_done = r_frame_done;
    assign overrun    = r_overrun;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_wave_channel_sched.sv
// Directed bench for wave_channel_sched (NCH=4, W=16, LAT=2) with a two-stage amp^phase datapath model.
module tb_wave_channel_sched;

    logic        clk;
    logic        reset_n;
    logic        cfg_we;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [1:0]  cfg_sel;
    logic [15:0] cfg_data;
    logic        run;
    logic        sample_tick;
    logic        dp_valid;
    logic [15:0] dp_amp;
    logic [15:0] dp_phase;
    logic [15:0] dp_result;
    logic        out_valid;
    logic [1:0]  out_ch;
    logic [15:0] out_data;
    logic        frame_done;
    logic        overrun;
    logic        overrun_clr;
    logic [1:0]  dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;

    wave_channel_sched #(.NCH(4), .W(16), .LAT(2)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cfg_we      (cfg_we),
        .cfg_ready   (cfg_ready),
        .cfg_ch      (cfg_ch),
        .cfg_sel     (cfg_sel),
        .cfg_data    (cfg_data),
        .run         (run),
        .sample_tick (sample_tick),
        .dp_valid    (dp_valid),
        .dp_amp      (dp_amp),
        .dp_phase    (dp_phase),
        .dp_result   (dp_result),
        .out_valid   (out_valid),
        .out_ch      (out_ch),
        .out_data    (out_data),
        .frame_done  (frame_done),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .dbg_state   (dbg_state)
    );

    // clock / datapath model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] dp_d1 = 16'h0000;
    logic [15:0] dp_d2 = 16'h0000;
    always @(posedge clk) begin
        dp_d1 <= dp_valid ? (dp_amp ^ dp_phase) : 16'hdead;
        dp_d2 <= dp_d1;
    end
    assign dp_result = dp_d2;

    // per-cycle capture of one frame, index = cycles after the tick cycle
    logic        cap_dpv [0:11];
    logic [15:0] cap_dpa [0:11];
    logic [15:0] cap_dpp [0:11];
    logic        cap_ov  [0:11];
    logic [1:0]  cap_och [0:11];
    logic [15:0] cap_od  [0:11];
    logic        cap_fd  [0:11];
    logic        cap_ovr [0:11];
    logic        cap_rdy [0:11];

    function automatic int cnt_dpv();
        int c = 0;
        for (int k = 1; k <= 10; k++) c += int'(cap_dpv[k]);
        return c;
    endfunction

    function automatic int cnt_ov();
        int c = 0;
        for (int k = 1; k <= 10; k++) c += int'(cap_ov[k]);
        return c;
    endfunction

    task automatic cfg_write(input logic [1:0] ch, input logic [1:0] sel, input logic [15:0] data);
        @(negedge clk);
        cfg_ch   = ch;
        cfg_sel  = sel;
        cfg_data = data;
        cfg_we   = 1'b1;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    // Tick in cycle 0, then capture cycles 1..10; optional extra tick / clear / write / run drop at cycle k.
    task automatic run_frame(input int extra_tick, input int clr_at, input int cfg_at, input int run_off_at);
        @(negedge clk);
        sample_tick = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            cap_dpv[k] = dp_valid;
            cap_dpa[k] = dp_amp;
            cap_dpp[k] = dp_phase;
            cap_ov[k]  = out_valid;
            cap_och[k] = out_ch;
            cap_od[k]  = out_data;
            cap_fd[k]  = frame_done;
            cap_ovr[k] = overrun;
            cap_rdy[k] = cfg_ready;
            sample_tick = (k == extra_tick);
            overrun_clr = (k == clr_at);
            cfg_we      = (k == cfg_at);
            if (k == run_off_at) run = 1'b0;
        end
        sample_tick = 1'b0;
        overrun_clr = 1'b0;
        cfg_we      = 1'b0;
    endtask

    task automatic test_reset();
        int busy;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        tests_run++; if (cfg_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_cfg_ready: got %b exp 1", cfg_ready); end
        tests_run++; if ({dp_valid, out_valid, frame_done, overrun} !== 4'b0000) begin tests_failed++; $display("FAIL reset_strobes: got %b exp 0000", {dp_valid, out_valid, frame_done, overrun}); end
        tests_run++; if ({dp_amp, dp_phase, out_data} !== 48'h0) begin tests_failed++; $display("FAIL reset_data: got %h exp 0", {dp_amp, dp_phase, out_data}); end
        tests_run++; if (dbg_state !== 2'd0) begin tests_failed++; $display("FAIL reset_state: got %0d exp 0", dbg_state); end

        cfg_write(2'd0, 2'd0, 16'h5555);
        cfg_write(2'd0, 2'd1, 16'h0f0f);
        cfg_write(2'd0, 2'd2, 16'h0100);
        @(negedge clk); sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b0;
        tests_run++; if ({dp_valid, overrun} !== 2'b11) begin tests_failed++; $display("FAIL reset_pre_issue: got %b exp 11", {dp_valid, overrun}); end
        #2 reset_n = 1'b0;
        #1;
        tests_run++; if ({dp_valid, out_valid, overrun} !== 3'b000) begin tests_failed++; $display("FAIL reset_async_abort: got %b exp 000", {dp_valid, out_valid, overrun}); end
        tests_run++; if (cfg_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_async_ready: got %b exp 1", cfg_ready); end
        @(negedge clk);
        reset_n = 1'b1;
        busy = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid || dp_valid) busy++;
        end
        tests_run++; if (busy !== 0) begin tests_failed++; $display("FAIL reset_no_residue: got %0d strobes exp 0", busy); end

        run_frame(0, 0, 0, 0);
        tests_run++; if ({cap_dpa[1], cap_dpp[1]} !== 32'h0) begin tests_failed++; $display("FAIL reset_regs_cleared: got %h exp 0", {cap_dpa[1], cap_dpp[1]}); end
    endtask

    task automatic test_single_frame();
        cfg_write(2'd0, 2'd2, 16'h0040);
        cfg_write(2'd0, 2'd1, 16'h0101);
        cfg_write(2'd0, 2'd0, 16'h1234);
        cfg_write(2'd2, 2'd0, 16'h00ff);
        run_frame(0, 0, 0, 0);
        tests_run++; if (cnt_dpv() !== 4 || cap_dpv[1] !== 1'b1 || cap_dpv[4] !== 1'b1) begin tests_failed++; $display("FAIL single_dp_valid: got %0d cycles exp 4 at 1-4", cnt_dpv()); end
        tests_run++; if (cap_dpp[1] !== 16'h0101) begin tests_failed++; $display("FAIL single_phase_ch0: got %h exp 0101", cap_dpp[1]); end
        tests_run++; if (cap_dpa[1] !== 16'h1234) begin tests_failed++; $display("FAIL single_amp_ch0: got %h exp 1234", cap_dpa[1]); end
        tests_run++; if ({cap_ov[3], cap_ov[4], cap_ov[5], cap_ov[6], cap_ov[7], cap_ov[8]} !== 6'b011110) begin tests_failed++; $display("FAIL single_out_valid: got %b exp 011110", {cap_ov[3], cap_ov[4], cap_ov[5], cap_ov[6], cap_ov[7], cap_ov[8]}); end
        tests_run++; if ({cap_och[4], cap_och[5], cap_och[6], cap_och[7]} !== 8'h1b) begin tests_failed++; $display("FAIL single_out_ch: got %h exp 1b", {cap_och[4], cap_och[5], cap_och[6], cap_och[7]}); end
        tests_run++; if ({cap_od[4], cap_od[5], cap_od[6]} !== 48'h1335_0000_00ff) begin tests_failed++; $display("FAIL single_out_data: got %h exp 1335000000ff", {cap_od[4], cap_od[5], cap_od[6]}); end
        tests_run++; if ({cap_fd[6], cap_fd[7], cap_fd[8]} !== 3'b010) begin tests_failed++; $display("FAIL single_frame_done: got %b exp 010", {cap_fd[6], cap_fd[7], cap_fd[8]}); end
        tests_run++; if ({cap_rdy[1], cap_rdy[7], cap_rdy[8]} !== 3'b001) begin tests_failed++; $display("FAIL single_cfg_ready: got %b exp 001", {cap_rdy[1], cap_rdy[7], cap_rdy[8]}); end
        run_frame(0, 0, 0, 0);
        tests_run++; if (cap_dpp[1] !== 16'h0141) begin tests_failed++; $display("FAIL single_phase_advance: got %h exp 0141", cap_dpp[1]); end
    endtask

    task automatic test_accumulate();
        logic [15:0] exp_ph [3];
        exp_ph[0] = 16'h0000;
        exp_ph[1] = 16'h8000;
        exp_ph[2] = 16'h0000;
        cfg_write(2'd1, 2'd2, 16'h8000);
        for (int f = 0; f < 3; f++) begin
            run_frame(0, 0, 0, 0);
            tests_run++; if (cap_dpp[2] !== exp_ph[f]) begin tests_failed++; $display("FAIL accum_wrap_%0d: got %h exp %h", f, cap_dpp[2], exp_ph[f]); end
        end
    endtask

    task automatic test_overrun();
        run_frame(2, 0, 0, 0);
        tests_run++; if ({cap_ovr[2], cap_ovr[3], cap_ovr[10]} !== 3'b011) begin tests_failed++; $display("FAIL overrun_set: got %b exp 011", {cap_ovr[2], cap_ovr[3], cap_ovr[10]}); end
        tests_run++; if (cnt_dpv() !== 4 || cnt_ov() !== 4) begin tests_failed++; $display("FAIL overrun_frame_intact: got %0d/%0d exp 4/4", cnt_dpv(), cnt_ov()); end
        tests_run++; if (cap_fd[7] !== 1'b1) begin tests_failed++; $display("FAIL overrun_frame_done: got %b exp 1", cap_fd[7]); end
        @(negedge clk); overrun_clr = 1'b1;
        @(negedge clk); overrun_clr = 1'b0;
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL overrun_clear: got %b exp 0", overrun); end
        run_frame(2, 2, 0, 0);
        tests_run++; if (cap_ovr[3] !== 1'b1) begin tests_failed++; $display("FAIL overrun_set_wins: got %b exp 1", cap_ovr[3]); end
        @(negedge clk); overrun_clr = 1'b1;
        @(negedge clk); overrun_clr = 1'b0;
    endtask

    task automatic test_config_gating();
        cfg_ch   = 2'd3;
        cfg_sel  = 2'd0;
        cfg_data = 16'h7fff;
        run_frame(0, 0, 5, 0);
        tests_run++; if (cap_rdy[5] !== 1'b0) begin tests_failed++; $display("FAIL cfg_ready_drain: got %b exp 0", cap_rdy[5]); end
        run_frame(0, 0, 0, 0);
        tests_run++; if (cap_dpa[4] !== 16'h0000) begin tests_failed++; $display("FAIL cfg_drop_busy: got %h exp 0000", cap_dpa[4]); end
        cfg_write(2'd3, 2'd0, 16'h7fff);
        cfg_write(2'd0, 2'd3, 16'hbeef);
        run_frame(0, 0, 0, 0);
        tests_run++; if (cap_dpa[4] !== 16'h7fff) begin tests_failed++; $display("FAIL cfg_amp_idle: got %h exp 7fff", cap_dpa[4]); end
        tests_run++; if (cap_od[7] !== 16'h7fff) begin tests_failed++; $display("FAIL cfg_amp_result: got %h exp 7fff", cap_od[7]); end
        tests_run++; if (cap_dpp[1] !== 16'h0101) begin tests_failed++; $display("FAIL cfg_acc_clear: got %h exp 0101", cap_dpp[1]); end
    endtask

    task automatic test_run_gate();
        run = 1'b0;
        run_frame(0, 0, 0, 0);
        tests_run++; if (cnt_dpv() !== 0 || cap_rdy[3] !== 1'b1) begin tests_failed++; $display("FAIL run_off_tick: got %0d issues rdy %b exp 0 rdy 1", cnt_dpv(), cap_rdy[3]); end
        run = 1'b1;
        run_frame(0, 0, 0, 2);
        tests_run++; if (cnt_dpv() !== 4 || cnt_ov() !== 4 || cap_fd[7] !== 1'b1) begin tests_failed++; $display("FAIL run_drop_completes: got %0d/%0d fd %b exp 4/4 fd 1", cnt_dpv(), cnt_ov(), cap_fd[7]); end
        run_frame(0, 0, 0, 0);
        tests_run++; if (cnt_dpv() !== 0) begin tests_failed++; $display("FAIL run_drop_next_tick: got %0d issues exp 0", cnt_dpv()); end
        run = 1'b1;
    endtask

    initial begin
        reset_n     = 1'b0;
        cfg_we      = 1'b0;
        cfg_ch      = 2'd0;
        cfg_sel     = 2'd0;
        cfg_data    = 16'h0000;
        run         = 1'b1;
        sample_tick = 1'b0;
        overrun_clr = 1'b0;
        test_reset();
        test_single_frame();
        test_accumulate();
        test_overrun();
        test_config_gating();
        test_run_gate();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
